uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 16x receiver. Configurable

---
 rtl/uart_rx_cfg_if.sv | 17 +
 rtl/uart_rx_cfg.sv | 133 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receiver line input, frame status pulses and the output valid/ready buffer
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
  logic                 en;
  logic                 rx;
  logic                 busy;
  logic                 done;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  modport master (output en, rx, out_ready,
                  input  busy, done, frame_err, parity_err, overrun, out_valid, out_data);
  modport slave  (input  en, rx, out_ready,
                  output busy, done, frame_err, parity_err, overrun, out_valid, out_data);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver with majority-vote sampling and buffered output
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_cfg_if.slave bus
);
  localparam int H  = OVERSAMPLE / 2;
  localparam int LN = $clog2(OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE * (DATA_BITS + 4));
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [1:0]           sync_q;
  logic [3:0]           hold_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        t_q, t_d;
  logic [BW-1:0]        b_q, b_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, out_q, out_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d, busy_q, busy_d;
  logic                 done_q, fe_q, pe_q, ov_q, ov_d, valid_q, valid_d;
  logic                 rx_s, tick, maj, start, fin, good, load;
  assign rx_s  = sync_q[1];
  assign tick  = t_q[LN-1:0] == LN'(H + 1);
  assign start = !rx_s && hold_q == 4'hF;
  // hold_q[1:0] are the two samples before rx_s, so at phase H+1 they are phases H-1 and H
  assign maj   = (hold_q[1] & hold_q[0]) | (hold_q[1] & rx_s) | (hold_q[0] & rx_s);
  always_comb begin
    state_d = state_q;
    t_d     = t_q + TW'(1);
    b_d     = b_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    busy_d  = busy_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        t_d     = TW'(1);
        b_d     = '0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        busy_d  = 1'b1;
      end
      START: if (tick) begin
        state_d = maj ? IDLE : DATA;
        busy_d  = !maj;
      end
      DATA: if (tick) begin
        sh_d = {maj, sh_q[DATA_BITS-1:1]};
        b_d  = b_q + BW'(1);
        if (b_q == BW'(DATA_BITS - 1)) begin
          b_d     = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        perr_d  = (^sh_q ^ 1'(PARITY_ODD)) != maj;
        state_d = STOP;
      end
      STOP: if (tick) begin
        ferr_d = ferr_q | !maj;
        b_d    = b_q + BW'(1);
        if (b_q == BW'(STOP_BITS - 1)) begin
          fin     = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.en) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      b_d     = '0;
      fin     = 1'b0;
    end
    if (state_d == IDLE) t_d = '0;
  end
  // a full buffer still accepts the new frame if the consumer drains it in the same cycle
  assign good    = fin && !ferr_d && !perr_d;
  assign load    = good && (!valid_q || bus.out_ready);
  assign ov_d    = good && valid_q && !bus.out_ready;
  assign valid_d = load || (valid_q && !bus.out_ready);
  assign out_d   = load ? sh_q : out_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '1;
      hold_q  <= '1;
      state_q <= IDLE;
      t_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], bus.rx};
      hold_q  <= {hold_q[2:0], rx_s};
      state_q <= state_d;
      t_q     <= t_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
      done_q  <= fin;
      fe_q    <= fin && ferr_d;
      pe_q    <= fin && perr_d;
      ov_q    <= ov_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.frame_err  = fe_q;
  assign bus.parity_err = pe_q;
  assign bus.overrun    = ov_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = out_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into 8N1/16x, 8E1/16x and 7O2/8x receivers
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   tdone = 0;
  int   dn[3], fe[3], pe[3], ov[3], vc[3];
  int   sd[3], sf[3], sp[3], so[3], sv[3];
  always #5 clk = ~clk;
  uart_rx_cfg_if #(.DATA_BITS(8)) ia ();
  uart_rx_cfg_if #(.DATA_BITS(8)) ib ();
  uart_rx_cfg_if #(.DATA_BITS(7)) ic ();
  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  initial for (int i = 0; i < 3; i++) begin
    dn[i] = 0; fe[i] = 0; pe[i] = 0; ov[i] = 0; vc[i] = 0;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    dn[0] <= dn[0] + int'(ia.done); fe[0] <= fe[0] + int'(ia.frame_err);
    pe[0] <= pe[0] + int'(ia.parity_err); ov[0] <= ov[0] + int'(ia.overrun);
    vc[0] <= vc[0] + int'(ia.out_valid);
    dn[1] <= dn[1] + int'(ib.done); fe[1] <= fe[1] + int'(ib.frame_err);
    pe[1] <= pe[1] + int'(ib.parity_err); ov[1] <= ov[1] + int'(ib.overrun);
    vc[1] <= vc[1] + int'(ib.out_valid);
    dn[2] <= dn[2] + int'(ic.done); fe[2] <= fe[2] + int'(ic.frame_err);
    pe[2] <= pe[2] + int'(ic.parity_err); ov[2] <= ov[2] + int'(ic.overrun);
    vc[2] <= vc[2] + int'(ic.out_valid);
    if (ic.done) tdone <= cyc;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    sd = dn; sf = fe; sp = pe; so = ov; sv = vc;
  endtask
  task automatic drive(input int s, input logic v);
    case (s)
      0:       ia.rx = v;
      1:       ib.rx = v;
      default: ic.rx = v;
    endcase
  endtask
  // f holds the frame LSB first (bit 0 = start); optional one-tick inversion at bit gb, tick gt
  task automatic send(input int s, input int n, input logic [15:0] f, input int nb,
                      input int gb = -1, input int gt = 0);
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < n; j++) begin
        drive(s, (i == gb && j == gt) ? ~f[i] : f[i]);
        if (i == 0 && j == 0) t0 = cyc;
        @(negedge clk);
      end
    drive(s, 1'b1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    ia.en = 1'b1; ia.rx = 1'b1; ia.out_ready = 1'b1;
    ib.en = 1'b1; ib.rx = 1'b1; ib.out_ready = 1'b1;
    ic.en = 1'b1; ic.rx = 1'b1; ic.out_ready = 1'b1;
    idle(3);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_out", ia.out_data, 0);
    rst_n = 1'b1;
    idle(8);
    snap();
    send(0, 16, 16'h34A, 10);
    idle(20);
    chk("t1_done", dn[0] - sd[0], 1);
    chk("t1_out", ia.out_data, 8'hA5);
    chk("t1_valid_cycles", vc[0] - sv[0], 1);
    chk("t1_errs", (fe[0] - sf[0]) + (pe[0] - sp[0]), 0);
    chk("t1_busy", ia.busy, 0);
    snap();
    send(1, 16, 16'h606, 11);
    idle(20);
    chk("t2_done", dn[1] - sd[1], 1);
    chk("t2_perr", pe[1] - sp[1], 1);
    chk("t2_valid_cycles", vc[1] - sv[1], 0);
    send(1, 16, 16'h406, 11);
    idle(20);
    chk("t2_good_out", ib.out_data, 8'h03);
    chk("t2_good_perr", pe[1] - sp[1], 1);
    chk("t2_good_valid", vc[1] - sv[1], 1);
    snap();
    send(0, 16, 16'h078, 10);
    idle(20);
    chk("t3_done", dn[0] - sd[0], 1);
    chk("t3_ferr", fe[0] - sf[0], 1);
    chk("t3_valid_cycles", vc[0] - sv[0], 0);
    send(0, 16, 16'h2B4, 10);
    idle(20);
    chk("t3_out", ia.out_data, 8'h5A);
    chk("t3_ferr_after", fe[0] - sf[0], 1);
    chk("t3_valid_after", vc[0] - sv[0], 1);
    snap();
    drive(0, 1'b0);
    idle(3);
    drive(0, 1'b1);
    idle(20);
    chk("t4_busy", ia.busy, 0);
    idle(20);
    chk("t4_done", dn[0] - sd[0], 0);
    chk("t4_flags", (fe[0] - sf[0]) + (pe[0] - sp[0]), 0);
    send(0, 16, 16'h34A, 10, 4, 8);
    idle(20);
    chk("t4_glitch_out", ia.out_data, 8'hA5);
    chk("t4_glitch_done", dn[0] - sd[0], 1);
    snap();
    drive(0, 1'b0);
    idle(40);
    chk("en_busy_pre", ia.busy, 1);
    ia.en = 1'b0;
    idle(2);
    chk("en_busy", ia.busy, 0);
    drive(0, 1'b1);
    idle(10);
    ia.en = 1'b1;
    idle(30);
    chk("en_done", dn[0] - sd[0], 0);
    ia.out_ready = 1'b0;
    snap();
    send(0, 16, 16'h222, 10);
    send(0, 16, 16'h244, 10);
    idle(20);
    chk("t5_done", dn[0] - sd[0], 2);
    chk("t5_overrun", ov[0] - so[0], 1);
    chk("t5_out", ia.out_data, 8'h11);
    chk("t5_valid", ia.out_valid, 1);
    ia.out_ready = 1'b1;
    idle(2);
    chk("t5_valid_clr", ia.out_valid, 0);
    chk("t5_out_hold", ia.out_data, 8'h11);
    ic.out_ready = 1'b0;
    snap();
    send(2, 8, 16'h654, 11);
    idle(20);
    chk("t6_first_out", ic.out_data, 7'h2A);
    chk("t6_first_valid", ic.out_valid, 1);
    chk("t6_first_perr", pe[2] - sp[2], 0);
    drive(2, 1'b0);
    idle(30);
    chk("t6_busy_pre", ic.busy, 1);
    rst_n = 1'b0;
    idle(2);
    chk("t6_rst_busy", ic.busy, 0);
    chk("t6_rst_valid", ic.out_valid, 0);
    chk("t6_rst_out", ic.out_data, 0);
    chk("t6_rst_out_a", ia.out_data, 0);
    rst_n = 1'b1;
    drive(2, 1'b1);
    ic.out_ready = 1'b1;
    idle(10);
    snap();
    send(2, 8, 16'h6FE, 11);
    idle(20);
    chk("t6_out", ic.out_data, 7'h7F);
    chk("t6_done", dn[2] - sd[2], 1);
    chk("t6_errs", (fe[2] - sf[2]) + (pe[2] - sp[2]), 0);
    // (F-1)*N+H+2 = 86 ticks from the first low rx_s, plus 2 synchronizer clocks
    chk("t6_latency", tdone - t0, 88);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
